// File: rtl/crt_txt_pkg.sv
// Shared definitions for the CRT text serializer: FIFO word layout, dot counts
// and the line-graphics character range.
package crt_txt_pkg;

  localparam int CURSOR_BIT = 24;
  localparam int CHAR_MSB   = 23;
  localparam int CHAR_LSB   = 16;
  localparam int ATTR_MSB   = 15;
  localparam int ATTR_LSB   = 8;
  localparam int FONT_MSB   = 7;
  localparam int FONT_LSB   = 0;

  localparam int DOTS_8 = 8;
  localparam int DOTS_9 = 9;

  localparam logic [7:0] LGR_LO = 8'hC0;
  localparam logic [7:0] LGR_HI = 8'hDF;

  typedef struct packed {
    logic       cursorx;
    logic [7:0] chr;
    logic [7:0] attr;
    logic [7:0] font;
  } txt_word_t;

endpackage

// File: rtl/crt_blink_ctr.sv
// Frame counter advanced on each rising edge of vsync; its upper bits pace
// character blink (bit 4) and cursor blink (bit 3).
module crt_blink_ctr #(
  parameter int BLINK_W = 5
) (
  input  logic t_crt_clk,
  input  logic hreset_n,
  input  logic c_vsync,
  output logic char_blink,
  output logic cursor_blink
);

  logic               vsync_d;
  logic [BLINK_W-1:0] frame_cnt;

  always_ff @(posedge t_crt_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      vsync_d   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vsync_d <= c_vsync;
      if (c_vsync && !vsync_d) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign char_blink   = frame_cnt[4];
  assign cursor_blink = frame_cnt[3];

endmodule

// File: rtl/crt_text_serializer.sv
// Text-mode dot serializer: pops char/attr/font words from the CRT FIFO and
// emits one 4-bit attribute index per dot. Optional underline: CRT_TXT_UNDERLINE_EN.
module crt_text_serializer
  import crt_txt_pkg::*;
#(
  parameter int FF_W    = 25,
  parameter int BLINK_W = 5
) (
  input  logic            t_crt_clk,
  input  logic            hreset_n,
  input  logic            text_mode,
  input  logic            c_vde,
  input  logic            c_hde,
  input  logic            c_vsync,
  input  logic [4:0]      c_slc_op,
  input  logic            sr01_b0,
  input  logic            ar10_b2,
  input  logic            ar10_b3,
  input  logic [7:0]      reg_cr0a_qout,
  input  logic [7:0]      reg_cr0b_qout,
  input  logic [7:0]      reg_cr14_qout,
  input  logic            ff_empty,
  input  logic [FF_W-1:0] ff_data,
  output logic            ff_rd,
  output logic [3:0]      pix_idx,
  output logic            pix_valid,
  output logic            char_clk,
  output logic            underflow
);

  logic       active, load, last;
  logic       char_blink, cursor_blink;
  logic [3:0] dot_cnt, last_dot;
  txt_word_t  head, cur, cur_q;
  logic       dot_on, cursor_on, blink_off, ul_on;
  logic [3:0] fg, bg, pix_nxt;

  logic unused_ok;
  assign unused_ok = ^{reg_cr0a_qout[7:6], reg_cr0b_qout[7:5], reg_cr14_qout};

  crt_blink_ctr #(.BLINK_W(BLINK_W)) u_blink (
    .t_crt_clk    (t_crt_clk),
    .hreset_n     (hreset_n),
    .c_vsync      (c_vsync),
    .char_blink   (char_blink),
    .cursor_blink (cursor_blink)
  );

  assign active   = text_mode & c_vde & c_hde;
  assign last_dot = sr01_b0 ? 4'(DOTS_8 - 1) : 4'(DOTS_9 - 1);
  assign last     = dot_cnt >= last_dot;
  // dot_cnt idles at 0, so dot 0 is both the first active cycle and the wrap
  assign load     = active & (dot_cnt == 4'd0);
  assign ff_rd    = load & ~ff_empty & hreset_n;

  always_comb begin
    head = '0;
    if (!ff_empty) begin
      head.cursorx = ff_data[CURSOR_BIT];
      head.chr     = ff_data[CHAR_MSB:CHAR_LSB];
      head.attr    = ff_data[ATTR_MSB:ATTR_LSB];
      head.font    = ff_data[FONT_MSB:FONT_LSB];
    end
  end

  // Dot 0 is taken straight from the FIFO head so the load costs no bubble
  assign cur = load ? head : cur_q;

  always_comb begin
    dot_on = 1'b0;
    if (!dot_cnt[3])
      dot_on = cur.font[~dot_cnt[2:0]];
    else if (ar10_b2 && cur.chr >= LGR_LO && cur.chr <= LGR_HI)
      dot_on = cur.font[0];
  end

`ifdef CRT_TXT_UNDERLINE_EN
  assign ul_on = (cur.attr[2:0] == 3'b001) && (c_slc_op == reg_cr14_qout[4:0]);
`else
  assign ul_on = 1'b0;
`endif

  assign fg        = cur.attr[3:0];
  assign bg        = ar10_b3 ? {1'b0, cur.attr[6:4]} : cur.attr[7:4];
  assign blink_off = ar10_b3 & cur.attr[7] & char_blink;
  assign cursor_on = cur.cursorx & ~reg_cr0a_qout[5] & cursor_blink &
                     (reg_cr0a_qout[4:0] <= c_slc_op) & (c_slc_op <= reg_cr0b_qout[4:0]);

  always_comb begin
    pix_nxt = bg;
    if (cursor_on)                   pix_nxt = fg;
    else if (!blink_off && (dot_on || ul_on)) pix_nxt = fg;
  end

  always_ff @(posedge t_crt_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      dot_cnt   <= '0;
      cur_q     <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
      char_clk  <= 1'b0;
      underflow <= 1'b0;
    end else if (!active) begin
      dot_cnt   <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
      char_clk  <= 1'b0;
    end else begin
      dot_cnt   <= last ? 4'd0 : dot_cnt + 4'd1;
      if (load) cur_q <= head;
      if (load && ff_empty) underflow <= 1'b1;
      pix_idx   <= pix_nxt;
      pix_valid <= 1'b1;
      char_clk  <= last;
    end
  end

endmodule

// File: tb/tb_crt_text_serializer.sv
// Directed bench for crt_text_serializer: table of per-character vectors plus
// hand sequences for underflow, inactive gating, mid-character abandon and reset.
module tb_crt_text_serializer;

  logic        t_crt_clk = 1'b0;
  logic        hreset_n;
  logic        text_mode, c_vde, c_hde, c_vsync;
  logic [4:0]  c_slc_op;
  logic        sr01_b0, ar10_b2, ar10_b3;
  logic [7:0]  reg_cr0a_qout, reg_cr0b_qout, reg_cr14_qout;
  logic        ff_empty;
  logic [24:0] ff_data;
  logic        ff_rd, pix_valid, char_clk, underflow;
  logic [3:0]  pix_idx;

  int checks = 0;
  int errors = 0;

  always #5 t_crt_clk = ~t_crt_clk;

  crt_text_serializer #(.FF_W(25), .BLINK_W(5)) dut (
    .t_crt_clk(t_crt_clk), .hreset_n(hreset_n), .text_mode(text_mode), .c_vde(c_vde),
    .c_hde(c_hde), .c_vsync(c_vsync), .c_slc_op(c_slc_op), .sr01_b0(sr01_b0),
    .ar10_b2(ar10_b2), .ar10_b3(ar10_b3), .reg_cr0a_qout(reg_cr0a_qout),
    .reg_cr0b_qout(reg_cr0b_qout), .reg_cr14_qout(reg_cr14_qout), .ff_empty(ff_empty),
    .ff_data(ff_data), .ff_rd(ff_rd), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .char_clk(char_clk), .underflow(underflow)
  );

  typedef struct {
    int          edges;   // vsync pulses applied before this character
    bit          s8;
    bit          b2;
    bit          b3;
    logic [7:0]  cr0a;
    logic [7:0]  cr0b;
    logic [4:0]  slc;
    logic [24:0] w;
    logic [35:0] exp;     // dot 0 in the top nibble
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic vsync(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge t_crt_clk) c_vsync = 1'b1;
      @(negedge t_crt_clk) c_vsync = 1'b0;
    end
  endtask

  // Called at a negedge; drives one character and checks every dot.
  task automatic run_char(input string tag, input logic [24:0] w, input logic emp,
                          input int n, input logic [35:0] exp);
    int rds;
    ff_data = w; ff_empty = emp; c_hde = 1'b1;
    #1 rds = int'(ff_rd);
    for (int i = 0; i < n; i++) begin
      @(negedge t_crt_clk);
      chk($sformatf("%s_pix%0d", tag, i), 32'(pix_idx), 32'(exp[35-4*i -: 4]));
      chk($sformatf("%s_vld%0d", tag, i), 32'(pix_valid), 32'd1);
      chk($sformatf("%s_cclk%0d", tag, i), 32'(char_clk), 32'(i == n - 1));
      if (i == n - 1) c_hde = 1'b0;
      #1 rds += int'(ff_rd);
    end
    chk($sformatf("%s_pops", tag), 32'(rds), emp ? 32'd0 : 32'd1);
    @(negedge t_crt_clk);
    chk($sformatf("%s_idle_vld", tag), 32'(pix_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [35:0] ul_exp;
`ifdef CRT_TXT_UNDERLINE_EN
    ul_exp = 36'h111111110;
`else
    ul_exp = 36'h101001010;
`endif
    //          edges s8 b2 b3 cr0a   cr0b   slc    word                         exp
    tbl[0]  = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[1]  = '{0,  0, 1, 0, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'hC4,8'h1E,8'h01}, 36'h1111111EE};
    tbl[2]  = '{0,  0, 1, 0, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'h41,8'h1E,8'h01}, 36'h1111111E1};
    tbl[3]  = '{0,  0, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'hC4,8'h1E,8'h01}, 36'h1111111E1};
    tbl[4]  = '{0,  1, 0, 1, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'h41,8'h9E,8'hA5}, 36'hE1E11E1E0};
    tbl[5]  = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b1,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[6]  = '{8,  1, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b1,8'h41,8'h07,8'hA5}, 36'h777777770};
    tbl[7]  = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0C, {1'b1,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[8]  = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0E, {1'b1,8'h41,8'h07,8'hA5}, 36'h777777770};
    tbl[9]  = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0F, {1'b1,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[10] = '{0,  1, 0, 0, 8'h2D, 8'h0E, 5'h0D, {1'b1,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[11] = '{0,  1, 0, 0, 8'h0E, 8'h0D, 5'h0D, {1'b1,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[12] = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'h41,8'h01,8'hA5}, ul_exp};
    tbl[13] = '{8,  1, 0, 1, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'h41,8'h9E,8'hA5}, 36'h111111110};
    tbl[14] = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b0,8'h41,8'h9E,8'hA5}, 36'hE9E99E9E0};
    tbl[15] = '{0,  1, 0, 0, 8'h0D, 8'h0E, 5'h0D, {1'b1,8'h41,8'h07,8'hA5}, 36'h707007070};
    tbl[16] = '{8,  1, 0, 1, 8'h0D, 8'h0E, 5'h0D, {1'b1,8'h41,8'h9E,8'hA5}, 36'hEEEEEEEE0};

    hreset_n = 1'b0; text_mode = 1'b1; c_vde = 1'b1; c_hde = 1'b0; c_vsync = 1'b0;
    c_slc_op = 5'h0D; sr01_b0 = 1'b1; ar10_b2 = 1'b0; ar10_b3 = 1'b0;
    reg_cr0a_qout = 8'h0D; reg_cr0b_qout = 8'h0E; reg_cr14_qout = 8'h0D;
    ff_empty = 1'b0; ff_data = '0;
    #23;
    chk("rst_pix", 32'(pix_idx), 32'd0);
    chk("rst_vld", 32'(pix_valid), 32'd0);
    chk("rst_cclk", 32'(char_clk), 32'd0);
    chk("rst_uflow", 32'(underflow), 32'd0);
    chk("rst_rd", 32'(ff_rd), 32'd0);
    @(negedge t_crt_clk) hreset_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      vsync(tbl[v].edges);
      @(negedge t_crt_clk);
      sr01_b0 = tbl[v].s8; ar10_b2 = tbl[v].b2; ar10_b3 = tbl[v].b3;
      reg_cr0a_qout = tbl[v].cr0a; reg_cr0b_qout = tbl[v].cr0b; c_slc_op = tbl[v].slc;
      run_char($sformatf("v%0d", v), tbl[v].w, 1'b0, tbl[v].s8 ? 8 : 9, tbl[v].exp);
    end
    chk("uflow_clean", 32'(underflow), 32'd0);

    // Empty FIFO at load: blank character, no pop, sticky underflow
    sr01_b0 = 1'b1; ar10_b2 = 1'b0; ar10_b3 = 1'b0; c_slc_op = 5'h0D;
    run_char("empty", {1'b0,8'h41,8'h07,8'hA5}, 1'b1, 8, 36'h000000000);
    chk("uflow_set", 32'(underflow), 32'd1);
    run_char("refill", {1'b0,8'h41,8'h07,8'hA5}, 1'b0, 8, 36'h707007070);
    chk("uflow_sticky", 32'(underflow), 32'd1);

    // text_mode low keeps the serializer idle even with c_hde high
    text_mode = 1'b0; c_hde = 1'b1;
    #1 chk("tm0_rd", 32'(ff_rd), 32'd0);
    @(negedge t_crt_clk); @(negedge t_crt_clk);
    chk("tm0_vld", 32'(pix_valid), 32'd0);
    c_hde = 1'b0; text_mode = 1'b1;
    @(negedge t_crt_clk);

    // Abandon a character after 3 dots; next active period reloads with one pop
    ff_data = {1'b0,8'h41,8'h07,8'hFF}; ff_empty = 1'b0; c_hde = 1'b1;
    repeat (3) @(negedge t_crt_clk);
    c_hde = 1'b0;
    @(negedge t_crt_clk);
    run_char("abandon", {1'b0,8'h42,8'h0C,8'h3C}, 1'b0, 8, 36'hCC0000CC0 ^ 36'hCCCCCCCC0);

    // Asynchronous reset at dot 4, then a fresh pop on the first active cycle
    ff_data = {1'b0,8'h41,8'h07,8'hFF}; c_hde = 1'b1;
    repeat (4) @(negedge t_crt_clk);
    hreset_n = 1'b0;
    #1;
    chk("arst_pix", 32'(pix_idx), 32'd0);
    chk("arst_vld", 32'(pix_valid), 32'd0);
    chk("arst_cclk", 32'(char_clk), 32'd0);
    chk("arst_uflow", 32'(underflow), 32'd0);
    chk("arst_rd", 32'(ff_rd), 32'd0);
    @(negedge t_crt_clk) hreset_n = 1'b1;
    run_char("post_rst", {1'b1,8'h41,8'h07,8'hA5}, 1'b0, 8, 36'h707007070);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
